// File: rtl/int_div_sched.sv
// int_div_sched: restoring integer divider shared by num_req requesters.
// A round-robin arbiter picks one request in IDLE; CALC retires one quotient
// bit per clock, MSB first; DONE holds the tagged result until resp_ready.
// Optional build macro: INT_DIV_SCHED_SHORTCUT_EN (single-cycle a<b and b==1).
module int_div_sched #(
    parameter int unsigned bitwidth = 32,
    parameter int unsigned num_req  = 4,
    parameter int unsigned id_width = $clog2(num_req)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req_valid,
    output logic [num_req-1:0]            req_ready,
    input  logic [num_req*bitwidth-1:0]   req_a,
    input  logic [num_req*bitwidth-1:0]   req_b,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [id_width-1:0]           resp_id,
    output logic [bitwidth-1:0]           resp_quotient,
    output logic [bitwidth-1:0]           resp_remainder,
    output logic                          resp_div_by_zero,
    output logic                          busy
);

    localparam int unsigned cnt_width = (bitwidth > 1) ? $clog2(bitwidth) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [id_width-1:0]    ptr_q, ptr_d;
    logic [id_width-1:0]    id_q, id_d;
    logic [bitwidth-1:0]    a_q, a_d;
    logic [bitwidth-1:0]    b_q, b_d;
    logic [bitwidth-1:0]    q_q, q_d;
    logic [bitwidth-1:0]    r_q, r_d;
    logic [cnt_width-1:0]   cnt_q, cnt_d;
    logic                   dbz_q, dbz_d;

    logic [id_width-1:0]    grant;
    logic [id_width-1:0]    cand;
    logic                   grant_vld;
    logic [bitwidth-1:0]    sel_a;
    logic [bitwidth-1:0]    sel_b;
    logic [bitwidth:0]      r_shift;
    logic [bitwidth:0]      r_diff;
    logic                   ge;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            cand = id_width'((32'(ptr_q) + i) % num_req);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
        sel_a = req_a[32'(grant)*bitwidth +: bitwidth];
        sel_b = req_b[32'(grant)*bitwidth +: bitwidth];
    end

    // Accept strobe: only in IDLE, only for the granted requester, never during reset.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && grant_vld) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Restoring step datapath; the borrow out of the (bitwidth+1)-bit subtract
    // is the inverted r' >= b compare, so one subtractor serves both.
    always_comb begin
        r_shift = {r_q, a_q[cnt_q]};
        r_diff  = r_shift - {1'b0, b_q};
        ge      = ~r_diff[bitwidth];
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    ptr_d   = (grant == id_width'(num_req - 1)) ? '0 : grant + 1'b1;
                    id_d    = grant;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    q_d     = '0;
                    r_d     = '0;
                    dbz_d   = 1'b0;
                    cnt_d   = cnt_width'(bitwidth - 1);
                    state_d = CALC;
                    if (sel_b == '0) begin
                        q_d     = '1;
                        r_d     = sel_a;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
`ifdef INT_DIV_SCHED_SHORTCUT_EN
                    else if (sel_a < sel_b) begin
                        q_d     = '0;
                        r_d     = sel_a;
                        state_d = DONE;
                    end else if (sel_b == bitwidth'(1)) begin
                        q_d     = sel_a;
                        r_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                q_d[cnt_q] = ge;
                r_d        = ge ? r_diff[bitwidth-1:0] : r_shift[bitwidth-1:0];
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign resp_valid       = (state_q == DONE);
    assign busy             = (state_q != IDLE);
    assign resp_id          = id_q;
    assign resp_quotient    = q_q;
    assign resp_remainder   = r_q;
    assign resp_div_by_zero = dbz_q;

endmodule

// File: tb/tb_int_div_sched.sv
// tb_int_div_sched: directed self-checking bench for int_div_sched.
module tb_int_div_sched;

    localparam int BW = 32;
    localparam int NR = 4;
    localparam int IW = 2;
`ifdef INT_DIV_SCHED_SHORTCUT_EN
    localparam int LAT_SC = 1;
`else
    localparam int LAT_SC = BW + 1;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*BW-1:0]   req_a;
    logic [NR*BW-1:0]   req_b;
    logic               resp_valid;
    logic               resp_ready;
    logic [IW-1:0]      resp_id;
    logic [BW-1:0]      resp_quotient;
    logic [BW-1:0]      resp_remainder;
    logic               resp_div_by_zero;
    logic               busy;

    int checks;
    int errors;

    int_div_sched #(.bitwidth(BW), .num_req(NR), .id_width(IW)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id(resp_id),
        .resp_quotient(resp_quotient),
        .resp_remainder(resp_remainder),
        .resp_div_by_zero(resp_div_by_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [BW-1:0] a, input logic [BW-1:0] b);
        req_a[id*BW +: BW] = a;
        req_b[id*BW +: BW] = b;
        req_valid[id]      = 1'b1;
    endtask

    // One full transaction with resp_ready held high; latency counts the
    // accepting edge as edge 1.
    task automatic do_div(input int id, input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input logic [BW-1:0] eq, input logic [BW-1:0] er,
                          input logic edz, input int elat, input string tag);
        int  lat;
        bit  got;
        resp_ready = 1'b1;
        set_req(id, a, b);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        check({tag, "_ready"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        @(negedge clk);
        check({tag, "_id"}, 64'(resp_id), 64'(id));
        check({tag, "_q"}, 64'(resp_quotient), 64'(eq));
        check({tag, "_r"}, 64'(resp_remainder), 64'(er));
        check({tag, "_dbz"}, 64'(resp_div_by_zero), 64'(edz));
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 1};
    logic [BW-1:0] exp_q [5] = '{32'd10, 32'd7, 32'd9, 32'd30, 32'd15};
    logic [BW-1:0] exp_r [5] = '{32'd0, 32'd1, 32'd0, 32'd10, 32'd2};

    initial begin
        int  n;
        int  nr;
        int  g;
        int  cyc;
        int  seen;
        bit  got;
        logic [BW-1:0] hq;
        logic [BW-1:0] hr;

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        // All four requesters valid from reset.
        set_req(0, 32'd100, 32'd10);
        set_req(1, 32'd50, 32'd7);
        set_req(2, 32'd81, 32'd9);
        set_req(3, 32'd1000, 32'd33);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_q", 64'(resp_quotient), 64'd0);
        check("rst_r", 64'(resp_remainder), 64'd0);
        check("rst_dbz", 64'(resp_div_by_zero), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Round robin 0,1,2,3 then re-raised requester 1 after 2 and 3.
        resp_ready = 1'b1;
        rst        = 1'b0;
        n   = 0;
        nr  = 0;
        cyc = 0;
        while ((n < 5 || nr < 5) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (resp_valid && nr < 5) begin
                check("rr_resp_id", 64'(resp_id), 64'(exp_order[nr]));
                check("rr_resp_q", 64'(resp_quotient), 64'(exp_q[nr]));
                check("rr_resp_r", 64'(resp_remainder), 64'(exp_r[nr]));
                nr++;
            end
            if (req_ready != '0 && n < 5) begin
                check("rr_onehot", 64'($onehot0(req_ready)), 64'd1);
                g = 0;
                for (int k = 0; k < NR; k++) if (req_ready[k]) g = k;
                check("rr_grant", 64'(g), 64'(exp_order[n]));
                n++;
                @(posedge clk); #1;
                req_valid[g] = 1'b0;
                if (n == 2) set_req(1, 32'd77, 32'd5);
            end
        end
        check("rr_grants_done", 64'(n), 64'd5);
        check("rr_resps_done", 64'(nr), 64'd5);
        @(posedge clk); #1;

        // Exact division and the divide-by-zero path.
        do_div(2, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, BW + 1, "single");
        do_div(0, 32'd6, 32'd3, 32'd2, 32'd0, 1'b0, BW + 1, "exact6_3");
        do_div(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, BW + 1, "exact_max");
        do_div(3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, BW + 1, "msb_div");
        do_div(2, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, "div0");

        // Backpressure in DONE: outputs frozen, no grants, then one handshake.
        resp_ready = 1'b0;
        set_req(0, 32'd6, 32'd3);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1'b1;
        end
        check("bp_ready", 64'(got), 64'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(3, 32'd9, 32'd2);
        cyc = 0;
        while (!resp_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_valid_rise", 64'(resp_valid), 64'd1);
        hq = resp_quotient;
        hr = resp_remainder;
        check("bp_hold_q0", 64'(hq), 64'd2);
        check("bp_hold_r0", 64'(hr), 64'd0);
        repeat (5) begin
            @(negedge clk);
            check("bp_q", 64'(resp_quotient), 64'(hq));
            check("bp_r", 64'(resp_remainder), 64'(hr));
            check("bp_id", 64'(resp_id), 64'd0);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake_valid", 64'(resp_valid), 64'd0);
        check("bp_handshake_busy", 64'(busy), 64'd0);
        check("bp_next_grant", 64'(req_ready), 64'b1000);
        req_valid[3] = 1'b0;
        #1;
        check("bp_withdraw", 64'(req_ready), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of CALC: no response, pointer back to requester 0.
        set_req(0, 32'd100, 32'd7);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1'b1;
        end
        check("mid_ready", 64'(got), 64'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_busy_async", 64'(busy), 64'd0);
        check("mid_valid_async", 64'(resp_valid), 64'd0);
        check("mid_q_async", 64'(resp_quotient), 64'd0);
        check("mid_r_async", 64'(resp_remainder), 64'd0);
        check("mid_id_async", 64'(resp_id), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("mid_no_resp", 64'(seen), 64'd0);
        @(posedge clk); #1;
        set_req(1, 32'd1, 32'd1);
        set_req(0, 32'd100, 32'd7);
        #1;
        check("mid_ptr_reset", 64'(req_ready), 64'b0001);
        req_valid[1] = 1'b0;
        do_div(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, BW + 1, "post_rst");

        // Shortcut-eligible operands: same results, latency depends on build.
        do_div(1, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, LAT_SC, "small_a");
        do_div(3, 32'd77, 32'd1, 32'd77, 32'd0, 1'b0, LAT_SC, "b_one");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends even if the DUT wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
